// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one aligned bus transaction per op, pipeline stalled until it completes.
// Minimum latency 3 stall cycles (IDLE, REQ, RESP) plus a DONE cycle; gnt/rvalid delays each add one stall cycle.
module mem_access_unit #(
  parameter int XLEN      = 64,
  parameter int MEMTYPE_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memRead_in,
  input  logic                 memWrite_in,
  input  logic [MEMTYPE_W-1:0] memType_in,
  input  logic [XLEN-1:0]      ALUResult_in,
  input  logic [XLEN-1:0]      writeData_in,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [XLEN-1:0]      bus_addr,
  output logic [XLEN-1:0]      bus_wdata,
  output logic [7:0]           bus_wstrb,
  input  logic                 bus_gnt,
  input  logic                 bus_rvalid,
  input  logic [XLEN-1:0]      bus_rdata,
  output logic [XLEN-1:0]      readData_out,
  output logic                 stall_out,
  output logic                 fault_out
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                 r_state, w_next;
  logic [XLEN-1:0]        r_addr, r_wdata, r_rdata;
  logic [7:0]             r_wstrb;
  logic                   r_we;
  logic [MEMTYPE_W-1:0]   r_type;
  logic [2:0]             r_lane;

  logic                   w_op, w_fault, w_misalign, w_capture;
  logic [1:0]             w_size;
  logic [2:0]             w_lane;
  logic [7:0]             w_strb_base;
  logic [XLEN-1:0]        w_shifted, w_load;

  assign w_op   = memRead_in | memWrite_in;
  assign w_size = memType_in[1:0];
  assign w_lane = ALUResult_in[2:0];

  // Unsigned encodings have no store meaning, so they fault on writes.
  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      2'd1:    w_misalign = ALUResult_in[0];
      2'd2:    w_misalign = |ALUResult_in[1:0];
      2'd3:    w_misalign = |ALUResult_in[2:0];
      default: w_misalign = 1'b0;
    endcase
    w_fault = w_misalign | (memType_in == 3'b111) | (memWrite_in & memType_in[2]);
  end

  always_comb begin
    w_strb_base = 8'h01;
    case (w_size)
      2'd0:    w_strb_base = 8'h01;
      2'd1:    w_strb_base = 8'h03;
      2'd2:    w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
  end

  assign w_shifted = bus_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_type)
      3'b000:  w_load = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_load = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_load = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    stall_out = 1'b0;
    fault_out = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op && w_fault) begin
          fault_out = 1'b1;
        end else if (w_op) begin
          stall_out = 1'b1;
          w_capture = 1'b1;
          w_next    = REQ;
        end
      end
      REQ: begin
        stall_out = 1'b1;
        if (bus_gnt) w_next = RESP;
      end
      RESP: begin
        stall_out = 1'b1;
        if (bus_rvalid) w_next = DONE;
      end
      // The completed op is still on EX/MEM here; releasing stall lets it leave without reissue.
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
      r_type  <= '0;
      r_lane  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_addr  <= {ALUResult_in[XLEN-1:3], 3'b000};
        r_wdata <= writeData_in << {w_lane, 3'b000};
        r_wstrb <= w_strb_base << w_lane;
        r_we    <= memWrite_in;
        r_type  <= memType_in;
        r_lane  <= w_lane;
      end
      if (r_state == RESP && bus_rvalid && !r_we) r_rdata <= w_load;
    end
  end

  assign bus_req      = (r_state == REQ);
  assign bus_we       = r_we;
  assign bus_addr     = r_addr;
  assign bus_wdata    = r_wdata;
  assign bus_wstrb    = r_wstrb;
  assign readData_out = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-transaction vectors plus multi-cycle corner sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_in, memWrite_in;
  logic [2:0]  memType_in;
  logic [63:0] ALUResult_in, writeData_in;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata, readData_out;
  logic [7:0]  bus_wstrb;
  logic        stall_out, fault_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .MEMTYPE_W(3)) dut (
    .clk(clk), .reset(reset),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in), .memType_in(memType_in),
    .ALUResult_in(ALUResult_in), .writeData_in(writeData_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .readData_out(readData_out), .stall_out(stall_out), .fault_out(fault_out)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  typ;
    logic [63:0] addr, wdata, rdata;
    logic        fault, we;
    logic [63:0] eaddr;
    logic [7:0]  estrb;
    logic [63:0] ewdata, erdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] t,
                              input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                              input logic f, input logic we, input logic [63:0] ea,
                              input logic [7:0] es, input logic [63:0] ew, input logic [63:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.typ = t; v.addr = a; v.wdata = wd; v.rdata = rdat;
    v.fault = f; v.we = we; v.eaddr = ea; v.estrb = es; v.ewdata = ew; v.erdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    memRead_in = 1'b0; memWrite_in = 1'b0; memType_in = 3'b000;
    ALUResult_in = '0; writeData_in = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  // One op with immediate gnt/rvalid; inputs driven 1 unit after the edge, outputs sampled on the falling edge.
  task automatic run_vec(input string tag, input vec_t v);
    @(posedge clk); #1;
    memRead_in = v.rd; memWrite_in = v.wr; memType_in = v.typ;
    ALUResult_in = v.addr; writeData_in = v.wdata;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = v.rdata;
    @(negedge clk);
    chk({tag, " fault"}, 64'(fault_out), 64'(v.fault));
    chk({tag, " stall c0"}, 64'(stall_out), 64'(!v.fault));
    if (v.fault) begin
      chk({tag, " req on fault"}, 64'(bus_req), 64'd0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk({tag, " fault one cycle"}, 64'(fault_out), 64'd0);
      chk({tag, " req after fault"}, 64'(bus_req), 64'd0);
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " req c1"}, 64'(bus_req), 64'd1);
      chk({tag, " we"}, 64'(bus_we), 64'(v.we));
      chk({tag, " addr"}, bus_addr, v.eaddr);
      chk({tag, " wstrb"}, 64'(bus_wstrb), 64'(v.estrb));
      chk({tag, " wdata"}, bus_wdata, v.ewdata);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " req c2"}, 64'(bus_req), 64'd0);
      chk({tag, " stall c2"}, 64'(stall_out), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " stall done"}, 64'(stall_out), 64'd0);
      chk({tag, " rdata"}, readData_out, v.erdata);
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt_s, cnt_r;
    vec_t lwu;

    vecs[0]  = mk(1,0,3'b000, 64'h1003, 0, 64'h0000_0000_8000_0000, 0,0, 64'h1000, 8'h08, 0, 64'hFFFF_FFFF_FFFF_FF80);
    vecs[1]  = mk(1,0,3'b100, 64'h1003, 0, 64'h0000_0000_8000_0000, 0,0, 64'h1000, 8'h08, 0, 64'h80);
    vecs[2]  = mk(0,1,3'b001, 64'h2006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 0,1, 64'h2000, 8'hC0, 64'h1234_0000_0000_0000, 64'h80);
    vecs[3]  = mk(1,0,3'b010, 64'h1002, 0, 0, 1,0, 0, 0, 0, 0);
    vecs[4]  = mk(1,0,3'b111, 64'h1000, 0, 0, 1,0, 0, 0, 0, 0);
    vecs[5]  = mk(1,0,3'b001, 64'h1006, 0, 64'h8001_0000_0000_0000, 0,0, 64'h1000, 8'hC0, 0, 64'hFFFF_FFFF_FFFF_8001);
    vecs[6]  = mk(1,0,3'b101, 64'h1006, 0, 64'h8001_0000_0000_0000, 0,0, 64'h1000, 8'hC0, 0, 64'h8001);
    vecs[7]  = mk(1,0,3'b010, 64'h1004, 0, 64'h8765_4321_0000_0000, 0,0, 64'h1000, 8'hF0, 0, 64'hFFFF_FFFF_8765_4321);
    vecs[8]  = mk(1,0,3'b011, 64'h1008, 0, 64'h0123_4567_89AB_CDEF, 0,0, 64'h1008, 8'hFF, 0, 64'h0123_4567_89AB_CDEF);
    vecs[9]  = mk(0,1,3'b100, 64'h1000, 64'h77, 0, 1,0, 0, 0, 0, 0);
    vecs[10] = mk(0,1,3'b011, 64'h1004, 64'h77, 0, 1,0, 0, 0, 0, 0);
    vecs[11] = mk(0,1,3'b010, 64'h1004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 0,1, 64'h1000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF);
    vecs[12] = mk(1,1,3'b011, 64'h2000, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 0,1, 64'h2000, 8'hFF, 64'h55, 64'h0123_4567_89AB_CDEF);

    reset = 1'b1;
    drive_idle();
    #22 reset = 1'b0;
    @(negedge clk);
    chk("rst req", 64'(bus_req), 64'd0);
    chk("rst wstrb", 64'(bus_wstrb), 64'd0);
    chk("rst addr", bus_addr, 64'd0);
    chk("rst rdata", readData_out, 64'd0);
    chk("rst stall", 64'(stall_out), 64'd0);
    chk("rst fault", 64'(fault_out), 64'd0);

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // LD with gnt held off 3 cycles and rvalid 2 cycles after gnt.
    cnt_s = 0; cnt_r = 0;
    @(posedge clk); #1;
    for (int c = 0; c <= 8; c++) begin
      memRead_in = (c <= 7); memType_in = 3'b011; ALUResult_in = 64'h3008;
      bus_gnt = (c == 4); bus_rvalid = (c == 6); bus_rdata = 64'hA5A5_0000_1234_5678;
      @(negedge clk);
      if (stall_out) cnt_s++;
      if (bus_req) begin
        cnt_r++;
        chk($sformatf("ld addr c%0d", c), bus_addr, 64'h3008);
        chk($sformatf("ld strb c%0d", c), 64'(bus_wstrb), 64'hFF);
      end
      if (c == 7) chk("ld rdata", readData_out, 64'hA5A5_0000_1234_5678);
      @(posedge clk); #1;
    end
    drive_idle();
    chk("ld stall cycles", 64'(cnt_s), 64'd7);
    chk("ld req cycles", 64'(cnt_r), 64'd4);

    // Reset in RESP of a load, then a stray rvalid, then a clean LWU.
    @(posedge clk); #1;
    memRead_in = 1'b1; memType_in = 3'b000; ALUResult_in = 64'h10; bus_gnt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst mid req", 64'(bus_req), 64'd0);
    chk("rst mid rdata", readData_out, 64'd0);
    memRead_in = 1'b0;
    #1;
    chk("rst mid idle", 64'(stall_out), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("stray rvalid rdata", readData_out, 64'd0);
    chk("stray rvalid req", 64'(bus_req), 64'd0);
    chk("stray rvalid stall", 64'(stall_out), 64'd0);
    @(posedge clk); #1;
    drive_idle();
    lwu = mk(1,0,3'b110, 64'h4004, 0, 64'hFEDC_BA98_0000_0000, 0,0, 64'h4000, 8'hF0, 0, 64'h0000_0000_FEDC_BA98);
    run_vec("lwu", lwu);

    // Back-to-back SW then LW at the same address.
    cnt_s = 0; cnt_r = 0;
    @(posedge clk); #1;
    for (int c = 0; c <= 10; c++) begin
      memWrite_in = (c <= 3); memRead_in = (c >= 4 && c <= 7);
      memType_in = 3'b010; ALUResult_in = 64'h5000; writeData_in = 64'h1111_2222;
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h9999_9999_7777_1111;
      @(negedge clk);
      if (stall_out) cnt_s++;
      if (bus_req) cnt_r++;
      if (c == 1) chk("b2b sw we", 64'(bus_we), 64'd1);
      if (c == 1) chk("b2b sw wdata", bus_wdata, 64'h1111_2222);
      if (c == 3) chk("b2b sw done", 64'(stall_out), 64'd0);
      if (c == 5) chk("b2b lw we", 64'(bus_we), 64'd0);
      if (c == 7) chk("b2b lw rdata", readData_out, 64'h7777_1111);
      @(posedge clk); #1;
    end
    drive_idle();
    chk("b2b req count", 64'(cnt_r), 64'd2);
    chk("b2b stall count", 64'(cnt_s), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
